pipe_scheduler: RTL and testbench
=================================

PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 The module SHALL have the following ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- run  in  1  1 = game scrolling; 0 = paused or game over.
- drawer_done  in  1  single-cycle completion pulse from the downstream pipe drawer.
- drawer_enable  out  1  draw request to the pipe drawer.
- pipe_x  out  11  right edge of the current pipe.
- pipe_y  out  11  top of the current bottom pipe.
- color  out  1  1 = draw pipe, 0 = erase with background.
- busy  out  1  frame update in progress.
- frame_overrun  out  1  one-cycle pulse when a tick is dropped.

REQ-002 The module SHALL have the following parameters (name, default, meaning):
- NUM_PIPES, 3, number of pipes tracked.
- SPACING, 220, horizontal pitch between pipes.
- OFFSCREEN_X, 710, pipe_x at or above this value is not drawn.
- Y_BASE, 220, minimum pipe_y value.

Function
REQ-003 Per pipe i, the module SHALL hold px[i] (11 bits) and py[i] (11 bits).
REQ-004 A frame_tick with run=1 and busy=0 SHALL start an update pass over pipes i=0..NUM_PIPES-1 in order.
REQ-005 Per pipe, the pass SHALL perform these steps in order:
- erase at the old px/py (color=0);
- move;
- draw at the new px/py (color=1).
REQ-006 The FSM states SHALL be IDLE, ERASE_REQ, ERASE_WAIT, MOVE, DRAW_REQ, DRAW_WAIT, NEXT, with these transitions:
- IDLE -> ERASE_REQ on an accepted tick.
- ERASE_REQ -> ERASE_WAIT if the old px < OFFSCREEN_X; otherwise -> MOVE.
- ERASE_WAIT -> MOVE when drawer_done=1.
- MOVE -> DRAW_REQ.
- DRAW_REQ -> DRAW_WAIT if the new px < OFFSCREEN_X; otherwise -> NEXT.
- DRAW_WAIT -> NEXT when drawer_done=1.
- NEXT -> ERASE_REQ for the next pipe, or -> IDLE after the last pipe.
REQ-007 drawer_enable SHALL be 1 exactly in ERASE_WAIT and DRAW_WAIT, so it falls in the cycle after drawer_done is sampled.
REQ-008 pipe_x, pipe_y and color SHALL be registered and SHALL be stable whenever drawer_enable=1.
REQ-009 In MOVE, the module SHALL set px := px-1.
REQ-010 If px-1 == 0, then instead:
- px := NUM_PIPES*SPACING (660);
- py := Y_BASE + zero-extended lfsr[6:0];
- the LFSR SHALL advance one step.
REQ-011 pipe_x=0 SHALL never be presented to the drawer.
REQ-012 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, and SHALL advance only on wrap.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 A frame_tick while busy=1 SHALL be ignored and SHALL pulse frame_overrun for exactly that cycle.
REQ-015 A frame_tick with run=0 SHALL be ignored without raising frame_overrun.
REQ-016 run falling mid-pass SHALL NOT abort the pass.
REQ-017 A drawer_done outside ERASE_WAIT/DRAW_WAIT SHALL be ignored.
REQ-018 drawer_done has no timeout; the FSM SHALL wait indefinitely.

Reset
REQ-019 Reset SHALL force the FSM to IDLE and drive drawer_enable=0, busy=0, frame_overrun=0, color=0, pipe_x=0, pipe_y=0.
REQ-020 Reset SHALL reload px = {660, 880, 1100}, py = {300, 260, 340} and lfsr = 16'hACE1.
REQ-021 Reset SHALL take priority over any in-progress pass; it SHALL NOT wait for drawer_done.

Structure
REQ-022 Package pipe_pkg SHALL hold:
- the FSM state typedef;
- the screen width (640), pipe width (70) and OFFSCREEN_X constants;
- the reset px/py tables;
- the LFSR seed.
REQ-023 A single sub-module lfsr16 SHALL be used, with ports clk, reset, step and 16-bit value.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then tick with run=1 -> enable with pipe_x=660, color=0, pipe_y=300; after done, enable with pipe_x=659, color=1; pipes 1 and 2 request nothing; px ends {659, 879, 1099}; busy falls.
- Preload px[0]=1 (659 ticks) -> erase at 1, then draw at pipe_x=660, pipe_y=317 (220+0x61), lfsr=next state after 16'hACE1.
- Second tick while busy -> frame_overrun high for exactly 1 cycle; px decremented once only.
- run=0 with 5 ticks -> no enable; px unchanged; frame_overrun stays 0.
- drawer_done withheld 1000 cycles in DRAW_WAIT -> enable stays 1; pipe_x/pipe_y/color constant; then done -> enable 0 the next cycle.
- Reset asserted in DRAW_WAIT -> next cycle enable=0, busy=0, px={660, 880, 1100}.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe scheduler slice:
// FSM states, screen geometry, reset tables and LFSR seed.
package pipe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_REQ,
        ERASE_WAIT,
        MOVE,
        DRAW_REQ,
        DRAW_WAIT,
        NEXT
    } state_t;

    localparam int SCREEN_W      = 640;
    localparam int PIPE_W        = 70;
    localparam int OFFSCREEN_X_C = SCREEN_W + PIPE_W;
    localparam int RST_PIPES     = 3;

    localparam logic [10:0] PX_RST [RST_PIPES] =
        '{11'd660, 11'd880, 11'd1100};
    localparam logic [10:0] PY_RST [RST_PIPES] =
        '{11'd300, 11'd260, 11'd340};

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [10:0] rst_px(input int i);
        return PX_RST[i % RST_PIPES];
    endfunction

    function automatic logic [10:0] rst_py(input int i);
        return PY_RST[i % RST_PIPES];
    endfunction

    // New pipe height after a wrap: only the low 7 LFSR bits matter.
    function automatic logic [10:0] wrap_y(
        input logic [10:0] base,
        input logic [15:0] lfsr
    );
        return base + {4'b0000, lfsr[6:0]};
    endfunction

endpackage

// File: rtl/pipe_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), steps only when asked.
module lfsr16
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;
    logic        fb;

    always_comb begin
        fb      = value_q[0] ^ value_q[2] ^ value_q[3] ^ value_q[5];
        value_d = value_q;
        if (step) begin
            value_d = {fb, value_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Per-frame pipe scroller: erases, moves and redraws each pipe
// through a handshake with the downstream pipe drawer.
module pipe_scheduler
    import pipe_pkg::*;
#(
    parameter int NUM_PIPES   = 3,
    parameter int SPACING     = 220,
    parameter int OFFSCREEN_X = OFFSCREEN_X_C,
    parameter int Y_BASE      = 220
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        drawer_done,
    output logic        drawer_enable,
    output logic [10:0] pipe_x,
    output logic [10:0] pipe_y,
    output logic        color,
    output logic        busy,
    output logic        frame_overrun
);

    localparam int IW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam logic [IW-1:0] LAST   = IW'(NUM_PIPES - 1);
    localparam logic [10:0]   OFF_X  = 11'(OFFSCREEN_X);
    localparam logic [10:0]   WRAP_X = 11'(NUM_PIPES * SPACING);
    localparam logic [10:0]   YB     = 11'(Y_BASE);

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [10:0]   px_q [NUM_PIPES];
    logic [10:0]   py_q [NUM_PIPES];
    logic          en_q;
    logic [10:0]   x_q;
    logic [10:0]   y_q;
    logic          color_q;
    logic          busy_q;

    logic [10:0]   px_cur;
    logic [10:0]   px_dec;
    logic          wrap;
    logic          lfsr_step;
    logic [15:0]   lfsr_value;

    assign px_cur    = px_q[idx_q];
    assign px_dec    = px_cur - 11'd1;
    assign wrap      = (px_dec == 11'd0);
    assign lfsr_step = (state_q == MOVE) && wrap;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            en_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                px_q[i] <= rst_px(i);
                py_q[i] <= rst_py(i);
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_tick && run) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ERASE_REQ;
                    end
                end
                ERASE_REQ: begin
                    if (px_cur < OFF_X) begin
                        x_q     <= px_cur;
                        y_q     <= py_q[idx_q];
                        color_q <= 1'b0;
                        en_q    <= 1'b1;
                        state_q <= ERASE_WAIT;
                    end else begin
                        state_q <= MOVE;
                    end
                end
                ERASE_WAIT: begin
                    if (drawer_done) begin
                        en_q    <= 1'b0;
                        state_q <= MOVE;
                    end
                end
                MOVE: begin
                    // Wrap instead of reaching x=0 so the drawer never sees it.
                    if (wrap) begin
                        px_q[idx_q] <= WRAP_X;
                        py_q[idx_q] <= wrap_y(YB, lfsr_value);
                    end else begin
                        px_q[idx_q] <= px_dec;
                    end
                    state_q <= DRAW_REQ;
                end
                DRAW_REQ: begin
                    if (px_cur < OFF_X) begin
                        x_q     <= px_cur;
                        y_q     <= py_q[idx_q];
                        color_q <= 1'b1;
                        en_q    <= 1'b1;
                        state_q <= DRAW_WAIT;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                DRAW_WAIT: begin
                    if (drawer_done) begin
                        en_q    <= 1'b0;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_q == LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ERASE_REQ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign drawer_enable = en_q;
    assign pipe_x        = x_q;
    assign pipe_y        = y_q;
    assign color         = color_q;
    assign busy          = busy_q;
    assign frame_overrun = frame_tick & busy_q & ~reset;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: randomized drawer latency against a
// request-list model of the erase/move/draw pass.
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        run;
    logic        drawer_done;
    logic        drawer_enable;
    logic [10:0] pipe_x;
    logic [10:0] pipe_y;
    logic        color;
    logic        busy;
    logic        frame_overrun;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x;
        int y;
        int c;
    } req_t;

    int          mpx [3];
    int          mpy [3];
    logic [15:0] mlfsr;
    req_t        expq [$];

    pipe_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .run           (run),
        .drawer_done   (drawer_done),
        .drawer_enable (drawer_enable),
        .pipe_x        (pipe_x),
        .pipe_y        (pipe_y),
        .color         (color),
        .busy          (busy),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    // Polynomial x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int   taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[k]) fb ^= v[16 - taps[k]];
        return {fb, v[15:1]};
    endfunction

    function automatic void model_reset();
        mpx   = '{660, 880, 1100};
        mpy   = '{300, 260, 340};
        mlfsr = 16'hACE1;
    endfunction

    // Builds the ordered drawer requests for one pass and moves pipes.
    function automatic void model_pass();
        expq.delete();
        for (int i = 0; i < 3; i++) begin
            if (mpx[i] < 710) expq.push_back('{mpx[i], mpy[i], 0});
            if (mpx[i] - 1 == 0) begin
                mpx[i] = 660;
                mpy[i] = 220 + int'(mlfsr[6:0]);
                mlfsr  = lfsr_next(mlfsr);
            end else begin
                mpx[i] = mpx[i] - 1;
            end
            if (mpx[i] < 710) expq.push_back('{mpx[i], mpy[i], 1});
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset       = 1'b1;
        frame_tick  = 1'b0;
        drawer_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        #1;
        checks++;
        if (frame_overrun !== 1'b0) begin
            errors++;
            $display("FAIL tick_overrun: got %b want 0", frame_overrun);
        end
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (drawer_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic serve_rest(input string tag);
        bit   fin = 1'b0;
        req_t r;
        int   lat;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (drawer_enable === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_req: x=%0d y=%0d c=%0d want none",
                             tag, pipe_x, pipe_y, color);
                    r = '{int'(pipe_x), int'(pipe_y), int'(color)};
                end else begin
                    r = expq.pop_front();
                    if (pipe_x !== 11'(r.x) || pipe_y !== 11'(r.y) ||
                        color !== 1'(r.c)) begin
                        errors++;
                        $display("FAIL %s_req: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                                 tag, pipe_x, pipe_y, color, r.x, r.y, r.c);
                    end
                end
                lat = $urandom_range(0, 3);
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    checks++;
                    if (drawer_enable !== 1'b1 || pipe_x !== 11'(r.x) ||
                        pipe_y !== 11'(r.y) || color !== 1'(r.c)) begin
                        errors++;
                        $display("FAIL %s_stable: got en=%b x=%0d y=%0d c=%0d want en=1 x=%0d y=%0d c=%0d",
                                 tag, drawer_enable, pipe_x, pipe_y, color,
                                 r.x, r.y, r.c);
                    end
                end
                drawer_done = 1'b1;
                @(negedge clk);
                drawer_done = 1'b0;
                checks++;
                if (drawer_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_en_fall: got %b want 0", tag, drawer_enable);
                end
            end
            if (busy === 1'b0) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b want 0", tag, busy);
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d unserved want 0", tag, expq.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut.px_q[i] !== 11'(mpx[i]) || dut.py_q[i] !== 11'(mpy[i])) begin
                errors++;
                $display("FAIL %s_pipe%0d: got px=%0d py=%0d want px=%0d py=%0d",
                         tag, i, dut.px_q[i], dut.py_q[i], mpx[i], mpy[i]);
            end
        end
        checks++;
        if (dut.lfsr_value !== mlfsr) begin
            errors++;
            $display("FAIL %s_lfsr: got %h want %h", tag, dut.lfsr_value, mlfsr);
        end
    endtask

    task automatic serve_pass(input string tag);
        model_pass();
        pulse_tick();
        serve_rest(tag);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({drawer_enable, busy, frame_overrun, color} !== 4'b0000 ||
            pipe_x !== 11'd0 || pipe_y !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b busy=%b ov=%b c=%b x=%0d y=%0d want all 0",
                     drawer_enable, busy, frame_overrun, color, pipe_x, pipe_y);
        end
        checks++;
        if (dut.px_q[0] !== 11'd660 || dut.px_q[1] !== 11'd880 ||
            dut.px_q[2] !== 11'd1100) begin
            errors++;
            $display("FAIL reset_px: got %0d %0d %0d want 660 880 1100",
                     dut.px_q[0], dut.px_q[1], dut.px_q[2]);
        end
        checks++;
        if (dut.py_q[0] !== 11'd300 || dut.py_q[1] !== 11'd260 ||
            dut.py_q[2] !== 11'd340) begin
            errors++;
            $display("FAIL reset_py: got %0d %0d %0d want 300 260 340",
                     dut.py_q[0], dut.py_q[1], dut.py_q[2]);
        end
        checks++;
        if (dut.lfsr_value !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_value);
        end
        frame_tick = 1'b0;
        reset      = 1'b0;
        model_reset();
    endtask

    task automatic test_first_pass();
        apply_reset();
        serve_pass("first");
        checks++;
        if (dut.px_q[0] !== 11'd659 || dut.px_q[1] !== 11'd879 ||
            dut.px_q[2] !== 11'd1099) begin
            errors++;
            $display("FAIL first_px_end: got %0d %0d %0d want 659 879 1099",
                     dut.px_q[0], dut.px_q[1], dut.px_q[2]);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        model_pass();
        pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        #1;
        checks++;
        if (frame_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %b want 1", frame_overrun);
        end
        @(negedge clk);
        frame_tick = 1'b0;
        #1;
        checks++;
        if (frame_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_width: got %b want 0", frame_overrun);
        end
        serve_rest("overrun");
        checks++;
        if (dut.px_q[0] !== 11'd659) begin
            errors++;
            $display("FAIL overrun_once: got px0=%0d want 659", dut.px_q[0]);
        end
    endtask

    task automatic test_run_low();
        int bad = 0;
        run = 1'b0;
        repeat (5) pulse_tick();
        @(negedge clk);
        drawer_done = 1'b1;
        @(negedge clk);
        drawer_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (drawer_enable !== 1'b0 || busy !== 1'b0 ||
                frame_overrun !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL run_low_idle: got %0d active cycles want 0", bad);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut.px_q[i] !== 11'(mpx[i])) begin
                errors++;
                $display("FAIL run_low_px%0d: got %0d want %0d", i, dut.px_q[i], mpx[i]);
            end
        end
        run = 1'b1;
    endtask

    task automatic test_withhold();
        bit ok;
        int bad = 0;
        apply_reset();
        model_pass();
        pulse_tick();
        wait_enable(ok);
        checks++;
        if (!ok || pipe_x !== 11'd660 || pipe_y !== 11'd300 || color !== 1'b0) begin
            errors++;
            $display("FAIL hold_erase: got ok=%b x=%0d y=%0d c=%b want 1 660 300 0",
                     ok, pipe_x, pipe_y, color);
        end
        drawer_done = 1'b1;
        @(negedge clk);
        drawer_done = 1'b0;
        wait_enable(ok);
        checks++;
        if (!ok || pipe_x !== 11'd659 || pipe_y !== 11'd300 || color !== 1'b1) begin
            errors++;
            $display("FAIL hold_draw: got ok=%b x=%0d y=%0d c=%b want 1 659 300 1",
                     ok, pipe_x, pipe_y, color);
        end
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (drawer_enable !== 1'b1 || pipe_x !== 11'd659 ||
                pipe_y !== 11'd300 || color !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d changed cycles want 0", bad);
        end
        drawer_done = 1'b1;
        @(negedge clk);
        drawer_done = 1'b0;
        checks++;
        if (drawer_enable !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got %b want 0", drawer_enable);
        end
        void'(expq.pop_front());
        void'(expq.pop_front());
        serve_rest("hold");
    endtask

    task automatic test_reset_midpass();
        bit ok;
        apply_reset();
        model_pass();
        pulse_tick();
        wait_enable(ok);
        drawer_done = 1'b1;
        @(negedge clk);
        drawer_done = 1'b0;
        wait_enable(ok);
        checks++;
        if (!ok || color !== 1'b1) begin
            errors++;
            $display("FAIL midrst_draw: got ok=%b c=%b want 1 1", ok, color);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if (drawer_enable !== 1'b0 || busy !== 1'b0 || color !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out: got en=%b busy=%b c=%b want 0 0 0",
                     drawer_enable, busy, color);
        end
        checks++;
        if (dut.px_q[0] !== 11'd660 || dut.px_q[1] !== 11'd880 ||
            dut.px_q[2] !== 11'd1100) begin
            errors++;
            $display("FAIL midrst_px: got %0d %0d %0d want 660 880 1100",
                     dut.px_q[0], dut.px_q[1], dut.px_q[2]);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int n = 0; n < 659; n++) serve_pass("walk");
        checks++;
        if (dut.px_q[0] !== 11'd1) begin
            errors++;
            $display("FAIL wrap_pre: got px0=%0d want 1", dut.px_q[0]);
        end
        serve_pass("wrap");
        checks++;
        if (dut.px_q[0] !== 11'd660 || dut.py_q[0] !== 11'd317) begin
            errors++;
            $display("FAIL wrap_pipe: got px=%0d py=%0d want 660 317",
                     dut.px_q[0], dut.py_q[0]);
        end
        checks++;
        if (dut.lfsr_value !== 16'h5670) begin
            errors++;
            $display("FAIL wrap_lfsr: got %h want 5670", dut.lfsr_value);
        end
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b1;
        frame_tick  = 1'b0;
        drawer_done = 1'b0;
        model_reset();
        test_reset();
        test_first_pass();
        test_overrun();
        test_run_low();
        test_withhold();
        test_reset_midpass();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
